fir_decim_mac: RTL and testbench



---
 rtl/fir_decim_mac.sv | 125 ++++++++++++
 tb/tb_fir_decim_mac.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_decim_mac.sv
// fir_decim_mac: sequential FIR filter with integer decimation.
// Pops DECIMATION samples from an upstream FWFT FIFO into a NUM_TAPS-deep
// history, runs one dequantizing MAC per cycle over the history, then
// pushes one result to the downstream FIFO.
// Build option: define FIR_SATURATE_EN to clamp the output to the
// DATA_SIZE signed range instead of wrapping it.
module fir_decim_mac #(
    parameter int DATA_SIZE  = 32,
    parameter int BITS       = 10,
    parameter int NUM_TAPS   = 8,
    parameter int DECIMATION = 1
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_TAPS*DATA_SIZE-1:0] coeffs,
    input  logic                          in_empty,
    output logic                          in_rd_en,
    input  logic [DATA_SIZE-1:0]          in_dout,
    input  logic                          out_full,
    output logic                          out_wr_en,
    output logic [DATA_SIZE-1:0]          out_din
);

    localparam int TAP_W = $clog2(NUM_TAPS);
    localparam int ACC_W = DATA_SIZE + TAP_W;
    localparam int CNT_W = $clog2(DECIMATION + 1);
    localparam int PRD_W = 2 * DATA_SIZE;

    // Bias added to negative products so the arithmetic shift truncates toward zero.
    localparam logic signed [PRD_W-1:0] RND = {{(PRD_W-BITS){1'b0}}, {BITS{1'b1}}};

    typedef enum logic [1:0] {S_LOAD, S_MAC, S_OUT} state_t;

    state_t                             state;
    logic [NUM_TAPS-1:0][DATA_SIZE-1:0] taps;
    logic [NUM_TAPS-1:0][DATA_SIZE-1:0] coeff_arr;
    logic [CNT_W-1:0]                   dec_cnt;
    logic [TAP_W-1:0]                   tap_idx;
    logic signed [ACC_W-1:0]            acc;

    logic signed [PRD_W-1:0]            prod;
    logic signed [PRD_W-1:0]            prod_adj;
    logic [DATA_SIZE-1:0]               mul_q;
    logic signed [ACC_W-1:0]            acc_nxt;
    logic [DATA_SIZE-1:0]               acc_red;
    logic                               pop;
    logic                               last_in;
    logic                               last_tap;

    assign coeff_arr = coeffs;
    assign pop       = in_rd_en;
    assign last_in   = (dec_cnt == CNT_W'(DECIMATION - 1));
    assign last_tap  = (tap_idx == TAP_W'(NUM_TAPS - 1));

    // Handshakes are combinational so a ready FIFO is served the same cycle.
    assign in_rd_en  = (state == S_LOAD) && !in_empty;
    assign out_wr_en = (state == S_OUT) && !out_full;

    // Dequantizing multiply of the selected tap, then the next accumulator value.
    always_comb begin
        prod     = $signed(taps[tap_idx]) * $signed(coeff_arr[tap_idx]);
        prod_adj = prod[PRD_W-1] ? (prod + RND) : prod;
        mul_q    = DATA_SIZE'(prod_adj >>> BITS);
        acc_nxt  = acc + {{TAP_W{mul_q[DATA_SIZE-1]}}, mul_q};
    end

    // Reduce the wide accumulator to the output width.
`ifdef FIR_SATURATE_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(TAP_W+1){1'b0}}, {(DATA_SIZE-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(TAP_W+1){1'b1}}, {(DATA_SIZE-1){1'b0}}};
    always_comb begin
        acc_red = acc_nxt[DATA_SIZE-1:0];
        if (acc_nxt > SAT_MAX)
            acc_red = SAT_MAX[DATA_SIZE-1:0];
        else if (acc_nxt < SAT_MIN)
            acc_red = SAT_MIN[DATA_SIZE-1:0];
    end
`else
    always_comb begin
        acc_red = acc_nxt[DATA_SIZE-1:0];
    end
`endif

    // Load / MAC / output sequencer with history, accumulator and output register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= S_LOAD;
            taps    <= '0;
            acc     <= '0;
            dec_cnt <= '0;
            tap_idx <= '0;
            out_din <= '0;
        end else begin
            case (state)
                S_LOAD: begin
                    if (pop) begin
                        taps <= {taps[NUM_TAPS-2:0], in_dout};
                        if (last_in) begin
                            dec_cnt <= '0;
                            acc     <= '0;
                            tap_idx <= '0;
                            state   <= S_MAC;
                        end else begin
                            dec_cnt <= dec_cnt + 1'b1;
                        end
                    end
                end
                S_MAC: begin
                    acc     <= acc_nxt;
                    tap_idx <= tap_idx + 1'b1;
                    if (last_tap) begin
                        out_din <= acc_red;
                        state   <= S_OUT;
                    end
                end
                S_OUT: begin
                    if (out_wr_en)
                        state <= S_LOAD;
                end
                default: state <= S_LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_decim_mac.sv
// tb_fir_decim_mac: directed vectors against two instances
// (DECIMATION=1 and DECIMATION=2) sharing clock, reset, coeffs and out_full.
// Expected values are hand-computed from the truncate-toward-zero MUL.
module tb_fir_decim_mac;

    localparam int DW = 32;
    localparam int NT = 8;

    logic               clock = 1'b0;
    logic               reset = 1'b0;
    logic [NT*DW-1:0]   coeffs = '0;
    logic               out_full = 1'b0;

    logic               in_empty, in_rd_en, out_wr_en;
    logic [DW-1:0]      in_dout, out_din;
    logic               in_empty2, in_rd_en2, out_wr_en2;
    logic [DW-1:0]      in_dout2, out_din2;

    fir_decim_mac #(.DATA_SIZE(DW), .BITS(10), .NUM_TAPS(NT), .DECIMATION(1)) dut (
        .clock(clock), .reset(reset), .coeffs(coeffs),
        .in_empty(in_empty), .in_rd_en(in_rd_en), .in_dout(in_dout),
        .out_full(out_full), .out_wr_en(out_wr_en), .out_din(out_din));

    fir_decim_mac #(.DATA_SIZE(DW), .BITS(10), .NUM_TAPS(NT), .DECIMATION(2)) dut2 (
        .clock(clock), .reset(reset), .coeffs(coeffs),
        .in_empty(in_empty2), .in_rd_en(in_rd_en2), .in_dout(in_dout2),
        .out_full(out_full), .out_wr_en(out_wr_en2), .out_din(out_din2));

    always #5 clock = ~clock;

    // FWFT source models: initial side owns wr pointers and data, always side owns rd pointers.
    logic [DW-1:0] src  [64];
    logic [DW-1:0] src2 [64];
    logic [5:0]    wr_ptr = '0, rd_ptr = '0, wr_ptr2 = '0, rd_ptr2 = '0;
    assign in_empty  = (wr_ptr == rd_ptr);
    assign in_dout   = src[rd_ptr];
    assign in_empty2 = (wr_ptr2 == rd_ptr2);
    assign in_dout2  = src2[rd_ptr2];

    int cyc = 0, nwr = 0, nwr2 = 0, pops2 = 0, both = 0, rd_empty = 0;
    int pop_cyc = 0, wr_cyc = 0;
    logic [DW-1:0] outs [256];
    logic [DW-1:0] outs2 [256];

    always @(posedge clock) cyc <= cyc + 1;

    // Pops, output capture and protocol monitors, all sampled at the active edge.
    always @(posedge clock) begin
        if (in_rd_en && !in_empty) begin
            rd_ptr  <= rd_ptr + 1'b1;
            pop_cyc <= cyc;
        end
        if (in_rd_en2 && !in_empty2) begin
            rd_ptr2 <= rd_ptr2 + 1'b1;
            pops2   <= pops2 + 1;
        end
        if (out_wr_en) begin
            outs[nwr & 255] <= out_din;
            nwr    <= nwr + 1;
            wr_cyc <= cyc;
        end
        if (out_wr_en2) begin
            outs2[nwr2 & 255] <= out_din2;
            nwr2 <= nwr2 + 1;
        end
        if ((in_rd_en && out_wr_en) || (in_rd_en2 && out_wr_en2)) both <= both + 1;
        if (in_rd_en2 && in_empty2) rd_empty <= rd_empty + 1;
    end

    int total = 0, bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [DW-1:0] v);
        src[wr_ptr] = v;
        wr_ptr = wr_ptr + 1'b1;
    endtask

    task automatic push2(input logic [DW-1:0] v);
        src2[wr_ptr2] = v;
        wr_ptr2 = wr_ptr2 + 1'b1;
    endtask

    task automatic wait_n(input string tag, input bit second, input int n);
        int k = 0;
        while (((second ? nwr2 : nwr) < n) && k < 300) begin
            @(negedge clock);
            k++;
        end
        chk(tag, second ? nwr2 : nwr, n);
    endtask

    task automatic do_reset(input logic [NT-1:0][DW-1:0] c);
        @(negedge clock);
        reset    = 1'b0;
        coeffs   = c;
        out_full = 1'b0;
        wr_ptr   = rd_ptr;
        wr_ptr2  = rd_ptr2;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
    endtask

    logic [NT-1:0][DW-1:0] c_t1, c_imp, c_max, c_one;
    int base, hi, chg;

    initial begin
        c_t1 = {32'hFFFFFFF3, 32'hFFFFFFE2, 32'hFFFFFFDF, 32'hFFFFFFE5,
                32'hFFFFFFED, 32'hFFFFFFF4, 32'hFFFFFFFA, 32'hFFFFFFFD};
        for (int i = 0; i < NT; i++) begin
            c_imp[i] = DW'((i + 1) * 1024);
            c_max[i] = 32'h7FFFFFFF;
            c_one[i] = 32'h00000400;
        end

        // reset state
        repeat (2) @(negedge clock);
        chk("rst_out_din", out_din, 0);
        chk("rst_wr_en", out_wr_en, 0);
        chk("rst_rd_en", in_rd_en, 0);

        // 1: basic MAC vector, truncation toward zero
        do_reset(c_t1);
        base = nwr;
        push(32'h000004A6); push(32'h000004A6); push(32'h00000696); push(32'hFFFFFB5A);
        push(32'hFFFFFC84); push(32'h000007D8); push(32'h00000900); push(32'h0000073E);
        wait_n("t1_count", 0, base + 8);
        chk("t1_out0", outs[base], 32'hFFFFFFFD);
        chk("t1_out1", outs[base + 1], 32'hFFFFFFF7);
        chk("t1_out7", outs[base + 7], 32'hFFFFFF9F);

        // 2: impulse response and latency
        do_reset(c_imp);
        base = nwr;
        push(32'h00000400);
        wait_n("t2_first", 0, base + 1);
        chk("t2_latency", wr_cyc - pop_cyc, NT + 1);
        for (int i = 0; i < NT; i++) push(32'h0);
        wait_n("t2_count", 0, base + NT + 1);
        for (int k = 0; k < NT; k++) chk($sformatf("t2_out%0d", k), outs[base + k], (k + 1) * 1024);
        chk("t2_tail", outs[base + NT], 0);

        // 3: backpressure holds S_OUT, then exactly one write
        do_reset(c_imp);
        base = nwr;
        out_full = 1'b1;
        push(32'h00000400);
        repeat (12) @(negedge clock);
        hi = 0; chg = 0;
        for (int i = 0; i < 20; i++) begin
            if (out_wr_en) hi++;
            if (out_din !== 32'd1024) chg++;
            @(negedge clock);
        end
        chk("t3_wr_low", hi, 0);
        chk("t3_stable", chg, 0);
        chk("t3_nowrite", nwr - base, 0);
        out_full = 1'b0;
        repeat (15) @(negedge clock);
        chk("t3_one_write", nwr - base, 1);
        chk("t3_value", outs[base], 1024);

        // 4: DECIMATION=2 with empty gaps
        do_reset(c_imp);
        base = nwr2;
        push2(32'h400); repeat (5) @(negedge clock);
        push2(32'h800); repeat (5) @(negedge clock);
        push2(32'hC00); repeat (5) @(negedge clock);
        push2(32'h1000); repeat (5) @(negedge clock);
        push2(32'h0); repeat (5) @(negedge clock);
        push2(32'h0);
        wait_n("t4_count", 1, base + 3);
        repeat (20) @(negedge clock);
        chk("t4_no_extra", nwr2 - base, 3);
        chk("t4_pops", pops2, 6);
        chk("t4_rd_empty", rd_empty, 0);
        chk("t4_out0", outs2[base], 4096);
        chk("t4_out1", outs2[base + 1], 20480);
        chk("t4_out2", outs2[base + 2], 40960);

        // 5: reset in the third MAC cycle
        do_reset(c_imp);
        base = nwr;
        push(32'h400);
        wait_n("t5_pre", 0, base + 1);
        @(negedge clock);
        push(32'h800);
        repeat (3) @(negedge clock);
        reset = 1'b0;
        #1;
        chk("t5_rst_out", out_din, 0);
        chk("t5_rst_wr", out_wr_en, 0);
        chk("t5_rst_rd", in_rd_en, 0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        repeat (15) @(negedge clock);
        chk("t5_no_stale", nwr - base, 1);
        push(32'h400);
        wait_n("t5_post", 0, base + 2);
        chk("t5_fresh", outs[base + 1], 1024);

        // 6a: max coeffs and inputs; each product wraps to -2^22, sum fits
        do_reset(c_max);
        base = nwr;
        for (int i = 0; i < NT; i++) push(32'h7FFFFFFF);
        wait_n("t6a_count", 0, base + NT);
        chk("t6a_out0", outs[base], 32'hFFC00000);
        chk("t6a_out7", outs[base + 7], 32'hFE000000);

        // 6b: positive overflow of the sum
        do_reset(c_one);
        base = nwr;
        for (int i = 0; i < NT; i++) push(32'h7FFFFFFF);
        wait_n("t6b_count", 0, base + NT);
`ifdef FIR_SATURATE_EN
        chk("t6b_out7", outs[base + 7], 32'h7FFFFFFF);
`else
        chk("t6b_out7", outs[base + 7], 32'hFFFFFFF8);
`endif

        // 6c: negative overflow of the sum
        do_reset(c_one);
        base = nwr;
        for (int i = 0; i < NT; i++) push(32'h80000000);
        wait_n("t6c_count", 0, base + NT);
`ifdef FIR_SATURATE_EN
        chk("t6c_out7", outs[base + 7], 32'h80000000);
`else
        chk("t6c_out7", outs[base + 7], 32'h00000000);
`endif

        chk("rd_wr_overlap", both, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
